if_stage: RTL and testbench

Instruction-fetch stage of the RSA-decryption ASIP pipeline, sitting directly upstream of `id_stage`. It owns the program counter, drives the instruction-memory address, and registers each fetched word with its PC+4 into the IF/ID pipeline register that `id_stage` decodes. It also accepts stall, flush and branch-redirect requests from later stages and runs a start/run/halt state machine.

---
 rtl/if_stage.sv | 96 +++++++++
 tb/tb_if_stage.sv | 132 +++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: instruction fetch with PC, IF/ID register and IDLE/RUN/HALT control; perf counters under IF_PERF_CNT_EN
module if_stage #(
    parameter int N = 32,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stall,
    input  logic         flush,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    output logic [N-1:0] imem_addr,
    input  logic [N-1:0] imem_rdata,
    output logic [N-1:0] pc,
    output logic [N-1:0] if_instruction,
    output logic [N-1:0] if_pc_plus4,
    output logic         if_valid,
    output logic         halted,
    output logic [N-1:0] fetch_count,
    output logic [N-1:0] bubble_count
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    state_t state, state_n;
    logic [N-1:0] pc_n, ins_n, p4_n, pc_plus4;
    logic v_n, is_halt;
    assign pc_plus4 = pc + N'(4);
    assign is_halt = imem_rdata[N-1 -: 3] == 3'b111;
    assign imem_addr = pc;
    assign halted = state == HALT;
    // state, PC and IF/ID register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pc <= RESET_PC;
            if_instruction <= '0;
            if_pc_plus4 <= '0;
            if_valid <= 1'b0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            if_instruction <= ins_n;
            if_pc_plus4 <= p4_n;
            if_valid <= v_n;
        end
    end
    // next state: redirect beats flush beats stall beats normal fetch; HALT word stops the PC
    always_comb begin
        state_n = state;
        pc_n = pc;
        ins_n = '0;
        p4_n = '0;
        v_n = 1'b0;
        case (state)
            IDLE: state_n = start ? RUN : IDLE;
            RUN: begin
                if (branch_taken) pc_n = branch_target;
                else if (flush) pc_n = pc_plus4;
                else if (stall) begin
                    ins_n = if_instruction;
                    p4_n = if_pc_plus4;
                    v_n = if_valid;
                end else begin
                    ins_n = imem_rdata;
                    p4_n = pc_plus4;
                    v_n = 1'b1;
                    pc_n = is_halt ? pc : pc_plus4;
                    state_n = is_halt ? HALT : RUN;
                end
            end
            HALT: begin
                pc_n = branch_taken ? branch_target : pc;
                state_n = branch_taken ? RUN : HALT;
            end
            default: state_n = IDLE;
        endcase
    end
`ifdef IF_PERF_CNT_EN
    logic fetch_inc, bub_inc;
    assign fetch_inc = state == RUN && !branch_taken && !flush && !stall;
    assign bub_inc = state == RUN && (branch_taken || flush);
    // count valid loads and RUN-state bubbles, wrapping naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= '0;
            bubble_count <= '0;
        end else begin
            if (fetch_inc) fetch_count <= fetch_count + N'(1);
            if (bub_inc) bubble_count <= bubble_count + N'(1);
        end
    end
`else
    assign fetch_count = '0;
    assign bubble_count = '0;
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks of fetch, stall, branch, flush, halt and wrap behaviour
module tb_if_stage;
    logic clk = 0, reset = 1, start = 0, stall = 0, flush = 0, branch_taken = 0;
    logic [31:0] branch_target = 0;
    logic [31:0] imem_addr, imem_rdata, pc, if_instruction, if_pc_plus4, fetch_count, bubble_count;
    logic if_valid, halted;
    logic [31:0] mem [8];
    int checks = 0, fails = 0;
    int fc = 0, bc = 0;
`ifdef IF_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    if_stage #(.N(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
        .if_instruction(if_instruction), .if_pc_plus4(if_pc_plus4), .if_valid(if_valid),
        .halted(halted), .fetch_count(fetch_count), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;
    assign imem_rdata = mem[imem_addr[4:2]];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_if(input string tag, input logic [31:0] p, input logic [31:0] ins,
                          input logic [31:0] p4, input logic v, input logic h);
        chk({tag, " pc"}, pc, p);
        chk({tag, " ins"}, if_instruction, ins);
        chk({tag, " pc4"}, if_pc_plus4, p4);
        chk({tag, " valid"}, {31'b0, if_valid}, {31'b0, v});
        chk({tag, " halted"}, {31'b0, halted}, {31'b0, h});
        chk({tag, " fcnt"}, fetch_count, PERF ? fc : 0);
        chk({tag, " bcnt"}, bubble_count, PERF ? bc : 0);
        chk({tag, " imem_addr"}, imem_addr, p);
    endtask

    initial begin
        mem[0] = 32'h00088000; mem[1] = 32'h01100029; mem[2] = 32'h00000222; mem[3] = 32'h20000003;
        mem[4] = 32'hC0000010; mem[5] = 32'hE0000000; mem[6] = 32'h60000006; mem[7] = 32'h40000007;
        #1;
        step();
        chk_if("reset", 0, 0, 0, 0, 0);
        reset = 0;
        step();
        chk_if("idle", 0, 0, 0, 0, 0);
        start = 1;
        step();
        start = 0;
        chk_if("start", 0, 0, 0, 0, 0);
        step();
        fc = 1;
        chk_if("fetch0", 4, 32'h00088000, 4, 1, 0);
        step();
        fc = 2;
        chk_if("fetch4", 8, 32'h01100029, 8, 1, 0);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_if("stall", 8, 32'h01100029, 8, 1, 0);
        end
        branch_taken = 1;
        branch_target = 32'h10;
        step();
        branch_taken = 0;
        stall = 0;
        bc = 1;
        chk_if("br_stall", 32'h10, 0, 0, 0, 0);
        step();
        fc = 3;
        chk_if("br_tgt", 32'h14, 32'hC0000010, 32'h14, 1, 0);
        step();
        fc = 4;
        chk_if("halt_fetch", 32'h14, 32'hE0000000, 32'h18, 1, 1);
        start = 1;
        step();
        start = 0;
        chk_if("halt_hold", 32'h14, 0, 0, 0, 1);
        branch_taken = 1;
        branch_target = 0;
        step();
        branch_taken = 0;
        chk_if("halt_exit", 0, 0, 0, 0, 0);
        step();
        fc = 5;
        chk_if("refetch0", 4, 32'h00088000, 4, 1, 0);
        step();
        fc = 6;
        chk_if("refetch4", 8, 32'h01100029, 8, 1, 0);
        flush = 1;
        step();
        flush = 0;
        bc = 2;
        chk_if("flush", 32'hC, 0, 0, 0, 0);
        branch_taken = 1;
        branch_target = 32'hFFFFFFFC;
        step();
        branch_taken = 0;
        bc = 3;
        chk_if("wrap_br", 32'hFFFFFFFC, 0, 0, 0, 0);
        step();
        fc = 7;
        chk_if("wrap", 0, 32'h40000007, 0, 1, 0);
        step();
        fc = 8;
        chk_if("post_wrap", 4, 32'h00088000, 4, 1, 0);
        reset = 1;
        start = 1;
        branch_taken = 1;
        branch_target = 32'h44;
        step();
        fc = 0;
        bc = 0;
        chk_if("mid_reset", 0, 0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
